// File: rtl/uart_result_pkg.sv
// ----------------------------------------------------------------------------
// uart_result_pkg : shared constants and state types for the result receiver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_result_pkg;

  localparam logic [7:0] MARKER_BYTE          = 8'h00;
  localparam logic [1:0] DATA_TAG             = 2'b01;
  localparam int         DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    REC_HUNT = 2'd0,
    REC_B1   = 2'd1,
    REC_B2   = 2'd2,
    REC_B3   = 2'd3
  } rec_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte : 8N1 deserialiser with line synchroniser and start-glitch reject
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import uart_result_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_sync1, r_sync2, r_prev;
  logic             w_fall;
  rx_state_t        r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [7:0]       r_data, w_data_n;
  logic             r_valid, w_valid_n;
  logic             r_ferr, w_ferr_n;

  // Presetting high keeps an idle line from looking like a start edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_n = '0;
        if (w_fall) begin
          w_state_n = RX_START;
          w_bit_n   = '0;
        end
      end
      RX_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_n   = '0;
          w_state_n = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_n   = '0;
          w_shift_n = {r_sync2, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_n   = '0;
          w_state_n = RX_IDLE;
          if (r_sync2) begin
            w_valid_n = 1'b1;
            w_data_n  = r_shift;
          end else begin
            w_ferr_n  = 1'b1;
          end
        end
      end
      default: w_state_n = RX_IDLE;
    endcase
  end

  assign byte_data   = r_data;
  assign byte_valid  = r_valid;
  assign frame_error = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_result_rx.sv
// ----------------------------------------------------------------------------
// uart_result_rx : decodes marker + three tagged bytes into 16-bit error counts
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_result_rx
  import uart_result_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int IDX_W        = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             uart_rxd,
  input  logic             clear,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             frame_error,
  output logic             record_valid,
  output logic [15:0]      record_count,
  output logic [IDX_W-1:0] record_index,
  output logic             first_fail_valid,
  output logic [IDX_W-1:0] first_fail_index,
  output logic             proto_error
);

  localparam logic [IDX_W-1:0] c_idx_max = {IDX_W{1'b1}};

  logic [7:0]       w_byte;
  logic             w_byte_valid, w_frame_error;
  logic             w_is_marker, w_is_data;
  logic [15:0]      w_new_count;

  rec_state_t       r_state, w_state_n;
  logic [5:0]       r_lo, w_lo_n, r_mid, w_mid_n;
  logic [IDX_W-1:0] r_next_idx, w_next_idx_n;
  logic [15:0]      r_count, w_count_n;
  logic [IDX_W-1:0] r_index, w_index_n;
  logic             r_rec_valid, w_rec_valid_n;
  logic             r_proto, w_proto_n;
  logic             r_ff_valid, w_ff_valid_n;
  logic [IDX_W-1:0] r_ff_index, w_ff_index_n;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rxd    (uart_rxd),
    .byte_data   (w_byte),
    .byte_valid  (w_byte_valid),
    .frame_error (w_frame_error)
  );

  assign w_is_marker = (w_byte == MARKER_BYTE);
  assign w_is_data   = (w_byte[7:6] == DATA_TAG);
  assign w_new_count = {w_byte[3:0], r_mid, r_lo};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= REC_HUNT;
      r_lo        <= '0;
      r_mid       <= '0;
      r_next_idx  <= '0;
      r_count     <= '0;
      r_index     <= '0;
      r_rec_valid <= 1'b0;
      r_proto     <= 1'b0;
      r_ff_valid  <= 1'b0;
      r_ff_index  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_lo        <= w_lo_n;
      r_mid       <= w_mid_n;
      r_next_idx  <= w_next_idx_n;
      r_count     <= w_count_n;
      r_index     <= w_index_n;
      r_rec_valid <= w_rec_valid_n;
      r_proto     <= w_proto_n;
      r_ff_valid  <= w_ff_valid_n;
      r_ff_index  <= w_ff_index_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_lo_n        = r_lo;
    w_mid_n       = r_mid;
    w_next_idx_n  = r_next_idx;
    w_count_n     = r_count;
    w_index_n     = r_index;
    w_rec_valid_n = 1'b0;
    w_proto_n     = 1'b0;
    w_ff_valid_n  = r_ff_valid;
    w_ff_index_n  = r_ff_index;

    if (w_frame_error) begin
      if (r_state != REC_HUNT) begin
        w_proto_n = 1'b1;
        w_state_n = REC_HUNT;
      end
    end else if (w_byte_valid) begin
      case (r_state)
        REC_HUNT: begin
          if (w_is_marker) w_state_n = REC_B1;
        end
        REC_B1, REC_B2: begin
          if (w_is_marker) begin
            w_proto_n = 1'b1;
            w_state_n = REC_B1;
          end else if (w_is_data) begin
            if (r_state == REC_B1) begin
              w_lo_n    = w_byte[5:0];
              w_state_n = REC_B2;
            end else begin
              w_mid_n   = w_byte[5:0];
              w_state_n = REC_B3;
            end
          end else begin
            w_proto_n = 1'b1;
            w_state_n = REC_HUNT;
          end
        end
        REC_B3: begin
          if (w_is_marker) begin
            w_proto_n = 1'b1;
            w_state_n = REC_B1;
          end else if (w_is_data && (w_byte[5:4] == 2'b00)) begin
            w_count_n     = w_new_count;
            w_index_n     = r_next_idx;
            w_rec_valid_n = 1'b1;
            w_state_n     = REC_HUNT;
            if (r_next_idx != c_idx_max) w_next_idx_n = r_next_idx + 1'b1;
            if ((w_new_count != 16'd0) && !r_ff_valid) begin
              w_ff_valid_n = 1'b1;
              w_ff_index_n = r_next_idx;
            end
          end else begin
            w_proto_n = 1'b1;
            w_state_n = REC_HUNT;
          end
        end
        default: w_state_n = REC_HUNT;
      endcase
    end

    // clear overrides a record completing in the same cycle
    if (clear) begin
      w_state_n     = REC_HUNT;
      w_next_idx_n  = '0;
      w_count_n     = '0;
      w_index_n     = '0;
      w_rec_valid_n = 1'b0;
      w_proto_n     = 1'b0;
      w_ff_valid_n  = 1'b0;
      w_ff_index_n  = '0;
    end
  end

  assign byte_data        = w_byte;
  assign byte_valid       = w_byte_valid;
  assign frame_error      = w_frame_error;
  assign record_valid     = r_rec_valid;
  assign record_count     = r_count;
  assign record_index     = r_index;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_index = r_ff_index;
  assign proto_error      = r_proto;

endmodule

`default_nettype wire

// File: tb/tb_uart_result_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_result_rx : randomized frames checked against a record-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_result_rx;

  localparam int CLKS  = 16;
  localparam int IDX_W = 9;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             uart_rxd;
  logic             clear;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             frame_error;
  logic             record_valid;
  logic [15:0]      record_count;
  logic [IDX_W-1:0] record_index;
  logic             first_fail_valid;
  logic [IDX_W-1:0] first_fail_index;
  logic             proto_error;

  uart_result_rx #(
    .CLKS_PER_BIT (CLKS),
    .IDX_W        (IDX_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .uart_rxd         (uart_rxd),
    .clear            (clear),
    .byte_data        (byte_data),
    .byte_valid       (byte_valid),
    .frame_error      (frame_error),
    .record_valid     (record_valid),
    .record_count     (record_count),
    .record_index     (record_index),
    .first_fail_valid (first_fail_valid),
    .first_fail_index (first_fail_index),
    .proto_error      (proto_error)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse totals sampled away from the active edge
  int tot_bv = 0, tot_fe = 0, tot_rv = 0, tot_pe = 0;
  always @(negedge clk) begin
    if (byte_valid)   tot_bv <= tot_bv + 1;
    if (frame_error)  tot_fe <= tot_fe + 1;
    if (record_valid) tot_rv <= tot_rv + 1;
    if (proto_error)  tot_pe <= tot_pe + 1;
  end

  // Reference model: records as a list of payload bytes following a marker
  bit         m_in_rec;
  logic [7:0] m_pl[$];
  int         m_next_idx;
  int         m_count;
  int         m_index;
  bit         m_ffv;
  int         m_ffi;
  logic [7:0] m_last_byte;
  int         e_bv, e_fe, e_rv, e_pe;

  task automatic model_clear();
    m_in_rec   = 1'b0;
    m_pl.delete();
    m_next_idx = 0;
    m_count    = 0;
    m_index    = 0;
    m_ffv      = 1'b0;
    m_ffi      = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    e_bv = 0; e_fe = 0; e_rv = 0; e_pe = 0;
    if (!ok) begin
      e_fe = 1;
      if (m_in_rec) e_pe = 1;
      m_in_rec = 1'b0;
    end else begin
      e_bv = 1;
      m_last_byte = b;
      if (!m_in_rec) begin
        if (b == 8'h00) begin
          m_in_rec = 1'b1;
          m_pl.delete();
        end
      end else if (b == 8'h00) begin
        e_pe = 1;
        m_pl.delete();
      end else if (b[7:6] == 2'b01 && (m_pl.size() < 2 || b[5:4] == 2'b00)) begin
        m_pl.push_back(b);
        if (m_pl.size() == 3) begin
          m_count = int'(m_pl[0][5:0]) + 64 * int'(m_pl[1][5:0]) + 4096 * int'(m_pl[2][3:0]);
          m_index = m_next_idx;
          e_rv = 1;
          if (m_count != 0 && !m_ffv) begin
            m_ffv = 1'b1;
            m_ffi = m_index;
          end
          if (m_next_idx < (1 << IDX_W) - 1) m_next_idx++;
          m_in_rec = 1'b0;
        end
      end else begin
        e_pe = 1;
        m_in_rec = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CLKS) @(negedge clk);
    end
    uart_rxd = ok;
    repeat (CLKS) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic frame_check(input logic [7:0] b, input bit ok);
    int bv0, fe0, rv0, pe0;
    bv0 = tot_bv; fe0 = tot_fe; rv0 = tot_rv; pe0 = tot_pe;
    model_frame(b, ok);
    send_frame(b, ok);
    #1;
    chk("byte_valid_pulses",  32'(tot_bv - bv0), 32'(e_bv));
    chk("frame_error_pulses", 32'(tot_fe - fe0), 32'(e_fe));
    chk("record_valid_pulses",32'(tot_rv - rv0), 32'(e_rv));
    chk("proto_error_pulses", 32'(tot_pe - pe0), 32'(e_pe));
    chk("byte_data",          32'(byte_data),        32'(m_last_byte));
    chk("record_count",       32'(record_count),     32'(m_count));
    chk("record_index",       32'(record_index),     32'(m_index));
    chk("first_fail_valid",   32'(first_fail_valid), 32'(m_ffv));
    chk("first_fail_index",   32'(first_fail_index), 32'(m_ffi));
  endtask

  task automatic send_record(input logic [15:0] cnt);
    frame_check(8'h00, 1'b1);
    frame_check({2'b01, cnt[5:0]}, 1'b1);
    frame_check({2'b01, cnt[11:6]}, 1'b1);
    frame_check({4'b0100, cnt[15:12]}, 1'b1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    chk("clear_count", 32'(record_count), 32'(0));
    chk("clear_index", 32'(record_index), 32'(0));
    chk("clear_ffv",   32'(first_fail_valid), 32'(0));
  endtask

  initial begin
    int bv0, fe0, r;
    logic [15:0] cnt;
    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    clear    = 1'b0;
    model_clear();
    m_last_byte = 8'h00;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;

    // Idle line: nothing happens
    repeat (10 * CLKS) @(negedge clk);
    #1;
    chk("idle_pulses", 32'(tot_bv + tot_fe + tot_rv + tot_pe), 32'(0));
    chk("rst_byte_data", 32'(byte_data), 32'(0));
    chk("rst_count", 32'(record_count), 32'(0));
    chk("rst_index", 32'(record_index), 32'(0));
    chk("rst_ffv", 32'(first_fail_valid), 32'(0));
    chk("rst_ffi", 32'(first_fail_index), 32'(0));

    // Reference record
    send_record(16'h3A85);
    chk("rec_3A85", 32'(record_count), 32'h3A85);
    chk("rec_3A85_ffv", 32'(first_fail_valid), 32'(1));

    // First-fail tracking over several records
    pulse_clear();
    send_record(16'h0000);
    send_record(16'h0000);
    send_record(16'h0007);
    chk("ff_idx2", 32'(first_fail_index), 32'(2));
    send_record(16'h0001);
    chk("ff_idx_held", 32'(first_fail_index), 32'(2));
    chk("rec_idx3", 32'(record_index), 32'(3));

    // Marker mid-record resyncs
    frame_check(8'h00, 1'b1);
    frame_check(8'h45, 1'b1);
    frame_check(8'h00, 1'b1);
    frame_check(8'h41, 1'b1);
    frame_check(8'h41, 1'b1);
    frame_check(8'h41, 1'b1);
    chk("resync_1041", 32'(record_count), 32'h1041);

    // Framing error, standalone then mid-record
    frame_check(8'h41, 1'b0);
    frame_check(8'h00, 1'b1);
    frame_check(8'h41, 1'b1);
    frame_check(8'h41, 1'b0);
    frame_check(8'h41, 1'b1);

    // Randomized traffic
    repeat (30) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        cnt = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        send_record(cnt);
      end else if (r < 8) begin
        frame_check(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        frame_check(8'($urandom_range(0, 255)), 1'b0);
      end
    end

    // Short low glitch is rejected
    bv0 = tot_bv; fe0 = tot_fe;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * CLKS) @(negedge clk);
    #1;
    chk("glitch_bv", 32'(tot_bv - bv0), 32'(0));
    chk("glitch_fe", 32'(tot_fe - fe0), 32'(0));

    // Asynchronous reset mid-byte
    send_record(16'h1041);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3 * CLKS) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(record_count), 32'(0));
    chk("arst_ffv",   32'(first_fail_valid), 32'(0));
    chk("arst_data",  32'(byte_data), 32'(0));
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    m_last_byte = 8'h00;
    repeat (2 * CLKS) @(negedge clk);
    send_record(16'h0123);
    chk("post_rst_idx", 32'(record_index), 32'(0));
    chk("post_rst_cnt", 32'(record_count), 32'h0123);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
